mem_arbiter: RTL

Shares the single off-chip memory port between the I-cache and D-cache miss/writeback interfaces of the pipelined RISC-V core. It grants one client at a time, drives a registered memory request, and returns the memory response plus a one-cycle ready pulse to the owning client. Fixed D-over-I priority by default, with optional round-robin. A watchdog aborts transactions the memory never answers.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one off-chip memory port between the I-cache and D-cache.
// One client is granted at a time and gets a registered memory request.
// The owner receives the response data and a one-cycle ready pulse.
// A watchdog aborts transactions that memory never answers.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests. Without it, the arbiter uses fixed D-over-I priority.
//
// Handshake: a client holds read/write (level) until its x_ready pulse.
// x_ready is high for exactly one cycle, in DONE. The client must drop its
// request by the following IDLE cycle. Memory sees mem_read/mem_write held
// constant until the single-cycle mem_ready, which is only honoured in SERVE.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  // A 1-bit counter is kept when the watchdog is disabled, so the widths stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             i_req;
  logic             d_req;
  logic             grant_d;
  logic             sel_read;
  logic             sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when the most recent grant went to D; reset means "last was I".
  logic last_d;
  assign grant_d = d_req & (~i_req | ~last_d);
`else
  assign grant_d = d_req;
`endif

  assign sel_read  = grant_d ? d_read  : i_read;
  assign sel_write = grant_d ? d_write : i_write;
  assign sel_addr  = grant_d ? d_addr  : i_addr;
  assign sel_wdata = grant_d ? d_wdata : i_wdata;

  // The counter saturates instead of wrapping. timeout_hit fires as the edge
  // completes the TIMEOUT-th SERVE cycle.
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_inc == CNT_LIM);

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Arbitration FSM with registered memory strobes, response data and ready pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state     <= grant_d ? SERVE_D : SERVE_I;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_write;
            mem_read  <= sel_read & ~sel_write;
            cnt       <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= grant_d;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          cnt <= cnt_inc;
          if (mem_ready) begin
            if (mem_read) begin
              if (state == SERVE_D) d_rdata <= mem_rdata;
              else                  i_rdata <= mem_rdata;
            end
            if (state == SERVE_D) d_ready <= 1'b1;
            else                  i_ready <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= 1'b1;
            state     <= IDLE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
